// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, CP0 register
// numbers, cause-register field offsets and the default handler vector base.
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SAVE_CAUSE = 3'd1,
        S_SAVE_EPC   = 3'd2,
        S_MASK       = 3'd3,
        S_RESTORE    = 3'd4
    } state_t;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int         CAUSE_IP_LSB  = 8;
    localparam int         CAUSE_EXC_LSB = 2;
    localparam int         CAUSE_EXC_W   = 5;
    localparam logic [4:0] EXC_CODE_INT  = 5'd0;

    localparam logic [31:0] DEFAULT_VECTOR_BASE = 32'h0000_0800;

endpackage

// File: rtl/int_ctrl_irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest set bit (bit 0 wins).
module irq_prio_enc #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    i_req,
    output logic            o_valid,
    output logic [IDXW-1:0] o_idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches irq edges, saves cause/EPC into CP0, masks IE
// and redirects to the handler vector; eret restores IE and returns to EPC.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               NIRQ        = 4,
    parameter logic [WIDTH-1:0] VECTOR_BASE = WIDTH'(DEFAULT_VECTOR_BASE)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [NIRQ-1:0]  irq,
    input  logic             ie,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] epc_in,
    input  logic             eret,
    output logic             cp0_we,
    output logic [4:0]       cp0_wsel,
    output logic [WIDTH-1:0] cp0_din,
    output logic             ie_zero,
    output logic             ie_one,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             busy
);

    localparam int IDXW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [NIRQ-1:0]   r_irq_q;
    logic [NIRQ-1:0]   r_pend;
    logic              r_eret_pend;
    logic [IDXW-1:0]   r_id;
    logic [WIDTH-1:0]  r_epc;
    logic [NIRQ-1:0]   r_ip;

    logic              w_valid;
    logic [IDXW-1:0]   w_idx;
    logic [NIRQ-1:0]   w_rise;
    logic [NIRQ-1:0]   w_clr;
    logic              w_eret_go;
    logic              w_accept;
    logic [WIDTH-1:0]  w_cause;

    irq_prio_enc #(
        .N    (NIRQ),
        .IDXW (IDXW)
    ) u_prio_enc (
        .i_req   (r_pend),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // A pending eret always beats a pending interrupt when the FSM is idle.
    assign w_rise    = irq & ~r_irq_q;
    assign w_eret_go = (r_state == S_IDLE) && (eret || r_eret_pend);
    assign w_accept  = (r_state == S_IDLE) && !w_eret_go && ie && w_valid;
    assign w_clr     = w_accept ? (NIRQ'(1) << w_idx) : '0;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_eret_go) begin
                    w_next_state = S_RESTORE;
                end else if (w_accept) begin
                    w_next_state = S_SAVE_CAUSE;
                end
            end
            S_SAVE_CAUSE: w_next_state = S_SAVE_EPC;
            S_SAVE_EPC:   w_next_state = S_MASK;
            default:      w_next_state = S_IDLE;
        endcase
    end

    // Clearing the accepted bit is applied before new edges so a same-cycle edge survives.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_irq_q     <= '0;
            r_pend      <= '0;
            r_eret_pend <= 1'b0;
            r_id        <= '0;
            r_epc       <= '0;
            r_ip        <= '0;
        end else begin
            r_irq_q <= irq;
            r_pend  <= (r_pend & ~w_clr) | w_rise;
            if (w_eret_go) begin
                r_eret_pend <= 1'b0;
            end else if (eret && (r_state != S_IDLE)) begin
                r_eret_pend <= 1'b1;
            end
            if (w_accept) begin
                r_id  <= w_idx;
                r_epc <= pc_in;
                r_ip  <= r_pend;
            end
        end
    end

    always_comb begin
        w_cause = '0;
        w_cause[CAUSE_IP_LSB +: NIRQ]         = r_ip;
        w_cause[CAUSE_EXC_LSB +: CAUSE_EXC_W] = EXC_CODE_INT;
    end

    always_comb begin
        cp0_we      = 1'b0;
        cp0_wsel    = '0;
        cp0_din     = '0;
        ie_zero     = 1'b0;
        ie_one      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_SAVE_CAUSE: begin
                cp0_we   = 1'b1;
                cp0_wsel = CP0_CAUSE;
                cp0_din  = w_cause;
            end
            S_SAVE_EPC: begin
                cp0_we   = 1'b1;
                cp0_wsel = CP0_EPC;
                cp0_din  = r_epc;
            end
            S_MASK: begin
                ie_zero     = 1'b1;
                redirect    = 1'b1;
                redirect_pc = VECTOR_BASE + (WIDTH'(r_id) << 2);
            end
            S_RESTORE: begin
                ie_one      = 1'b1;
                redirect    = 1'b1;
                redirect_pc = epc_in;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: each scenario pushes the expected strobe
// cycles, and a monitor pops and compares them as the DUT produces them.
module tb_int_ctrl;

    localparam logic [31:0] VB = 32'h0000_0800;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  sel;
        logic [31:0] din;
        logic        iz;
        logic        io;
        logic        rd;
        logic [31:0] rpc;
    } exp_t;

    logic        clk;
    logic        clr_n;
    logic [3:0]  irq;
    logic        ie;
    logic [31:0] pc_in;
    logic [31:0] epc_in;
    logic        eret;
    logic        cp0_we;
    logic [4:0]  cp0_wsel;
    logic [31:0] cp0_din;
    logic        ie_zero;
    logic        ie_one;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    exp_t q[$];
    int   cyc = 0;
    int   nChecks = 0;
    int   nFail = 0;
    int   k;

    int_ctrl dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .irq         (irq),
        .ie          (ie),
        .pc_in       (pc_in),
        .epc_in      (epc_in),
        .eret        (eret),
        .cp0_we      (cp0_we),
        .cp0_wsel    (cp0_wsel),
        .cp0_din     (cp0_din),
        .ie_zero     (ie_zero),
        .ie_one      (ie_one),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] irqV, input logic ieV, input logic eretV);
        irq  = irqV;
        ie   = ieV;
        eret = eretV;
    endtask

    task automatic pushExp(input int c, input logic we, input logic [4:0] sel, input logic [31:0] din,
                           input logic iz, input logic io, input logic rd, input logic [31:0] rpc);
        exp_t e;
        e.cyc = c; e.we = we; e.sel = sel; e.din = din;
        e.iz = iz; e.io = io; e.rd = rd; e.rpc = rpc;
        q.push_back(e);
    endtask

    // Full service sequence accepted at edge c: cause, EPC, then mask+redirect.
    task automatic expectIrqSeq(input int c, input logic [3:0] ip, input logic [31:0] epc, input int id);
        pushExp(c,     1'b1, 5'd13, {20'd0, ip, 8'd0}, 1'b0, 1'b0, 1'b0, 32'd0);
        pushExp(c + 1, 1'b1, 5'd14, epc,               1'b0, 1'b0, 1'b0, 32'd0);
        pushExp(c + 2, 1'b0, 5'd0,  32'd0,             1'b1, 1'b0, 1'b1, VB + 32'(4 * id));
    endtask

    task automatic expectRestore(input int c, input logic [31:0] epc);
        pushExp(c, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, epc);
    endtask

    always @(posedge clk) begin
        #1;
        if (cp0_we || ie_zero || ie_one || redirect) begin
            if (q.size() == 0) begin
                checkOutput("spuriousStrobe", {cp0_we, ie_zero, ie_one, redirect}, 4'b0000);
            end else begin
                exp_t e;
                e = q.pop_front();
                checkOutput("cycle",      64'(cyc), 64'(e.cyc));
                checkOutput("cp0_we",     cp0_we, e.we);
                checkOutput("cp0_wsel",   cp0_wsel, e.sel);
                checkOutput("cp0_din",    cp0_din, e.din);
                checkOutput("ie_zero",    ie_zero, e.iz);
                checkOutput("ie_one",     ie_one, e.io);
                checkOutput("redirect",   redirect, e.rd);
                checkOutput("redirectPc", redirect_pc, e.rpc);
                checkOutput("busyActive", busy, 1'b1);
            end
        end else begin
            checkOutput("idleBusy", busy, 1'b0);
            checkOutput("idleSel",  cp0_wsel, 5'd0);
            checkOutput("idleDin",  cp0_din, 32'd0);
            checkOutput("idleRpc",  redirect_pc, 32'd0);
        end
    end

    initial begin
        clr_n = 1'b0; pc_in = '0; epc_in = '0;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        step(3);
        checkOutput("rstBusy",  busy, 1'b0);
        checkOutput("rstWe",    cp0_we, 1'b0);
        checkOutput("rstRedir", redirect, 1'b0);
        clr_n = 1'b1;
        step(2);

        // Single request on bit 2.
        pc_in = 32'h0000_1234;
        applyStimulus(4'b0100, 1'b1, 1'b0);
        k = cyc + 2;
        expectIrqSeq(k, 4'b0100, 32'h0000_1234, 2);
        step(6);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        step(2);

        // Two simultaneous requests; second waits until ie returns.
        applyStimulus(4'b0110, 1'b1, 1'b0);
        k = cyc + 2;
        expectIrqSeq(k, 4'b0110, 32'h0000_1234, 1);
        step(2);
        applyStimulus(4'b0110, 1'b0, 1'b0);
        step(8);
        pc_in = 32'h0000_5678;
        applyStimulus(4'b0110, 1'b1, 1'b0);
        expectIrqSeq(cyc + 1, 4'b0100, 32'h0000_5678, 2);
        step(6);

        // ie low: request accumulates silently, then re-arrives on acceptance.
        applyStimulus(4'b0000, 1'b0, 1'b0);
        step(2);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        step(1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        step(5);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        k = cyc + 1;
        expectIrqSeq(k,     4'b0001, 32'h0000_5678, 0);
        expectIrqSeq(k + 4, 4'b0001, 32'h0000_5678, 0);
        step(10);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        step(2);

        // eret while idle redirects in the very next cycle.
        epc_in = 32'h0000_2000;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        expectRestore(cyc + 1, 32'h0000_2000);
        step(1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        step(3);

        // Two erets while busy collapse to one restore, ahead of a new irq.
        pc_in  = 32'h0000_3000;
        epc_in = 32'h0000_1234;
        applyStimulus(4'b1000, 1'b1, 1'b0);
        k = cyc + 2;
        expectIrqSeq(k, 4'b1000, 32'h0000_3000, 3);
        expectRestore(k + 4, 32'h0000_1234);
        expectIrqSeq(k + 6, 4'b0001, 32'h0000_3000, 0);
        step(3);
        applyStimulus(4'b1001, 1'b1, 1'b1);
        step(1);
        applyStimulus(4'b1001, 1'b1, 1'b1);
        step(1);
        applyStimulus(4'b1001, 1'b1, 1'b0);
        step(10);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        step(2);

        // Reset mid-sequence aborts it and drops the remaining request.
        applyStimulus(4'b0011, 1'b1, 1'b0);
        k = cyc + 2;
        pushExp(k, 1'b1, 5'd13, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 clr_n = 1'b0;
        #1;
        checkOutput("abortWe",   cp0_we, 1'b0);
        checkOutput("abortBusy", busy, 1'b0);
        checkOutput("abortDin",  cp0_din, 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        step(2);
        clr_n = 1'b1;
        step(8);

        checkOutput("queueEmpty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
